// File: rtl/vx_onehot_collector_if.sv
// Handshake/bus bundle for vx_onehot_collector.
// Input side: a beat (valid_in, index_in, last_in) moves when valid_in && ready_in.
// Output side: a group (valid_out + mask/count/dup/err) moves when valid_out && ready_out.
// Producers must hold a beat stable until accepted; the collector holds a group
// stable until it is accepted.
interface vx_onehot_collector_if #(
  parameter int N  = 1,
  parameter int LN = (N > 1) ? $clog2(N) : 1,
  parameter int CW = $clog2(N + 1)
);
  logic          valid_in;
  logic [LN-1:0] index_in;
  logic          last_in;
  logic          ready_in;
  logic          valid_out;
  logic [N-1:0]  mask_out;
  logic [CW-1:0] count_out;
  logic          dup_out;
  logic          err_out;
  logic          ready_out;

  // Collector side.
  modport slave (
    input  valid_in, index_in, last_in, ready_out,
    output ready_in, valid_out, mask_out, count_out, dup_out, err_out
  );

  // Producer/consumer side.
  modport master (
    output valid_in, index_in, last_in, ready_out,
    input  ready_in, valid_out, mask_out, count_out, dup_out, err_out
  );
endinterface

// File: rtl/vx_onehot_collector.sv
// vx_onehot_collector: ORs a group of decoded index beats into a one-hot mask,
// counting distinct bits and flagging repeated indices. A beat with last_in
// closes the group, which is then held until the consumer accepts it.
// Optional feature: define VX_ONEHOT_COLLECTOR_RANGE_CHECK_EN to make
// out-of-range indices raise a sticky err_out; otherwise err_out is tied low.
// Out-of-range indices never set a mask bit in either build.
module vx_onehot_collector #(
  parameter int N       = 1,
  parameter int REVERSE = 0,
  parameter int LN      = (N > 1) ? $clog2(N) : 1,
  parameter int CW      = $clog2(N + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_onehot_collector_if.slave   bus,
  output logic [1:0]             state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state_q;
  logic          valid_q;
  logic [N-1:0]  mask_q;
  logic [CW-1:0] count_q;
  logic          dup_q;

  logic          accept;
  logic          in_range;
  logic          new_bit;
  logic          fresh;
  logic [N-1:0]  dec;
  logic [N-1:0]  base_mask;
  logic [CW-1:0] base_count;
  logic          base_dup;

  // A held group blocks new beats unless the consumer takes it this cycle.
  assign bus.ready_in = (state_q != HOLD) || bus.ready_out;
  assign accept       = bus.valid_in && bus.ready_in;
  assign in_range     = (32'(bus.index_in) < 32'(N));

  // Decode the index into its mask bit; REVERSE mirrors the bit order.
  always_comb begin
    dec = '0;
    for (int b = 0; b < N; b++) begin
      if (32'(bus.index_in) == 32'((REVERSE != 0) ? (N - 1 - b) : b)) begin
        dec[b] = 1'b1;
      end
    end
  end

  // A beat accepted while a group is held starts a new group from scratch.
  always_comb begin
    fresh      = (state_q == HOLD);
    base_mask  = fresh ? '0 : mask_q;
    base_count = fresh ? '0 : count_q;
    base_dup   = fresh ? 1'b0 : dup_q;
    new_bit    = |(dec & ~base_mask);
  end

`ifdef VX_ONEHOT_COLLECTOR_RANGE_CHECK_EN
  logic err_q;
  logic base_err;

  assign base_err = fresh ? 1'b0 : err_q;

  // Sticky out-of-range flag, following the group lifecycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= base_err | ~in_range;
    end else if (state_q == HOLD && bus.ready_out) begin
      err_q <= 1'b0;
    end
  end

  assign bus.err_out = err_q;
`else
  assign bus.err_out = 1'b0;
`endif

  // Group FSM with registered mask, count, dup flag and valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
    end else if (accept) begin
      mask_q  <= base_mask | dec;
      count_q <= base_count + CW'(new_bit);
      dup_q   <= base_dup | (in_range & ~new_bit);
      if (bus.last_in) begin
        state_q <= HOLD;
        valid_q <= 1'b1;
      end else begin
        state_q <= ACCUM;
        valid_q <= 1'b0;
      end
    end else if (state_q == HOLD && bus.ready_out) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      mask_q  <= '0;
      count_q <= '0;
      dup_q   <= 1'b0;
    end
  end

  assign bus.valid_out = valid_q;
  assign bus.mask_out  = mask_q;
  assign bus.count_out = count_q;
  assign bus.dup_out   = dup_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_vx_onehot_collector.sv
// Directed bench for vx_onehot_collector: a vector table on an N=8 instance,
// plus short sequences on REVERSE, N=5 and N=1 instances and around reset.
module tb_vx_onehot_collector;

`ifdef VX_ONEHOT_COLLECTOR_RANGE_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [1:0] st0, st1, st2, st3;

  vx_onehot_collector_if #(.N(8), .LN(3), .CW(4)) b0 ();
  vx_onehot_collector_if #(.N(8), .LN(3), .CW(4)) b1 ();
  vx_onehot_collector_if #(.N(5), .LN(3), .CW(3)) b2 ();
  vx_onehot_collector_if #(.N(1), .LN(1), .CW(1)) b3 ();

  vx_onehot_collector #(.N(8), .REVERSE(0), .LN(3), .CW(4)) dut0 (.clk(clk), .reset(reset), .bus(b0), .state_o(st0));
  vx_onehot_collector #(.N(8), .REVERSE(1), .LN(3), .CW(4)) dut1 (.clk(clk), .reset(reset), .bus(b1), .state_o(st1));
  vx_onehot_collector #(.N(5), .REVERSE(0), .LN(3), .CW(3)) dut2 (.clk(clk), .reset(reset), .bus(b2), .state_o(st2));
  vx_onehot_collector #(.N(1), .REVERSE(0), .LN(1), .CW(1)) dut3 (.clk(clk), .reset(reset), .bus(b3), .state_o(st3));

  // Clock
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] idx;
    logic       last;
    logic       ro;
    logic       e_rdy;
    logic       e_vo;
    logic [7:0] e_mask;
    logic [3:0] e_cnt;
    logic       e_dup;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic v, input logic [2:0] idx, input logic last, input logic ro,
                     input logic e_rdy, input logic e_vo, input logic [7:0] e_mask,
                     input logic [3:0] e_cnt, input logic e_dup);
    vec_t r;
    r.v = v; r.idx = idx; r.last = last; r.ro = ro; r.e_rdy = e_rdy;
    r.e_vo = e_vo; r.e_mask = e_mask; r.e_cnt = e_cnt; r.e_dup = e_dup;
    tbl.push_back(r);
  endtask

  task automatic drive0(input logic v, input logic [2:0] idx, input logic last, input logic ro);
    @(negedge clk);
    b0.valid_in = v; b0.index_in = idx; b0.last_in = last; b0.ready_out = ro;
    @(posedge clk); #1;
  endtask

  task automatic check0(input string tag, input logic e_vo, input logic [7:0] e_mask,
                        input logic [3:0] e_cnt, input logic e_dup);
    check({tag, ".valid_out"}, 32'(b0.valid_out), 32'(e_vo));
    check({tag, ".mask_out"},  32'(b0.mask_out),  32'(e_mask));
    check({tag, ".count_out"}, 32'(b0.count_out), 32'(e_cnt));
    check({tag, ".dup_out"},   32'(b0.dup_out),   32'(e_dup));
    check({tag, ".err_out"},   32'(b0.err_out),   32'(1'b0));
  endtask

  initial begin
    b0.valid_in = 0; b0.index_in = 0; b0.last_in = 0; b0.ready_out = 0;
    b1.valid_in = 0; b1.index_in = 0; b1.last_in = 0; b1.ready_out = 0;
    b2.valid_in = 0; b2.index_in = 0; b2.last_in = 0; b2.ready_out = 0;
    b3.valid_in = 0; b3.index_in = 0; b3.last_in = 0; b3.ready_out = 0;

    //          v idx last ro | rdy vo  mask          cnt dup
    add(1, 3, 0, 0,  1, 0, 8'b0000_1000, 1, 0);
    add(1, 5, 0, 0,  1, 0, 8'b0010_1000, 2, 0);
    add(1, 0, 1, 0,  1, 1, 8'b0010_1001, 3, 0);  // 3,5,0 group
    add(1, 7, 1, 0,  0, 1, 8'b0010_1001, 3, 0);  // held, beat blocked
    add(1, 7, 1, 0,  0, 1, 8'b0010_1001, 3, 0);
    add(1, 7, 1, 0,  0, 1, 8'b0010_1001, 3, 0);
    add(1, 7, 1, 0,  0, 1, 8'b0010_1001, 3, 0);
    add(1, 7, 1, 1,  1, 1, 8'h80,        1, 0);  // release + new group, no bubble
    add(1, 2, 0, 1,  1, 0, 8'b0000_0100, 1, 0);  // release + open group
    add(1, 2, 1, 0,  1, 1, 8'b0000_0100, 1, 1);  // repeat index
    add(0, 0, 0, 1,  1, 0, 8'h00,        0, 0);  // release to IDLE
    add(0, 0, 0, 0,  1, 0, 8'h00,        0, 0);
    add(1, 2, 0, 0,  1, 0, 8'b0000_0100, 1, 0);  // 2,2 from idle
    add(1, 2, 1, 0,  1, 1, 8'b0000_0100, 1, 1);
    add(0, 0, 0, 1,  1, 0, 8'h00,        0, 0);
    add(1, 6, 1, 0,  1, 1, 8'b0100_0000, 1, 0);  // single-beat group
    add(1, 1, 0, 1,  1, 0, 8'b0000_0010, 1, 0);
    add(1, 0, 0, 0,  1, 0, 8'b0000_0011, 2, 0);
    add(1, 7, 1, 0,  1, 1, 8'b1000_0011, 3, 0);
    add(0, 0, 0, 1,  1, 0, 8'h00,        0, 0);

    // Reset block
    repeat (2) @(posedge clk);
    #1;
    check0("rst", 0, 8'h00, 0, 0);
    check("rst.state", 32'(st0), 32'd0);
    @(negedge clk); reset = 0;
    @(posedge clk); #1;
    check("post_rst.ready_in", 32'(b0.ready_in), 32'd1);

    // Vector table on the N=8 instance
    for (int k = 0; k < tbl.size(); k++) begin
      @(negedge clk);
      b0.valid_in = tbl[k].v; b0.index_in = tbl[k].idx;
      b0.last_in = tbl[k].last; b0.ready_out = tbl[k].ro;
      #1;
      check($sformatf("v%0d.ready_in", k), 32'(b0.ready_in), 32'(tbl[k].e_rdy));
      @(posedge clk); #1;
      check0($sformatf("v%0d", k), tbl[k].e_vo, tbl[k].e_mask, tbl[k].e_cnt, tbl[k].e_dup);
    end

    // Reset discards a partial group
    drive0(1, 1, 0, 0);
    drive0(1, 4, 0, 0);
    check0("partial", 0, 8'b0001_0010, 2, 0);
    @(negedge clk); reset = 1; b0.valid_in = 0;
    @(posedge clk); #1;
    check0("rst_mid", 0, 8'h00, 0, 0);
    @(negedge clk); reset = 0;
    drive0(1, 0, 1, 0);
    check0("after_rst", 1, 8'b0000_0001, 1, 0);
    // Reset discards a held group
    @(negedge clk); reset = 1; b0.valid_in = 0;
    @(posedge clk); #1;
    check0("rst_hold", 0, 8'h00, 0, 0);
    check("rst_hold.state", 32'(st0), 32'd0);
    @(negedge clk); reset = 0;

    // REVERSE=1
    @(negedge clk); b1.valid_in = 1; b1.index_in = 0; b1.last_in = 1; b1.ready_out = 0;
    @(posedge clk); #1;
    check("rev0.valid_out", 32'(b1.valid_out), 32'd1);
    check("rev0.mask_out",  32'(b1.mask_out),  32'h80);
    check("rev0.count_out", 32'(b1.count_out), 32'd1);
    @(negedge clk); b1.index_in = 7; b1.ready_out = 1;
    @(posedge clk); #1;
    check("rev7.mask_out",  32'(b1.mask_out),  32'h01);
    check("rev7.count_out", 32'(b1.count_out), 32'd1);
    @(negedge clk); b1.valid_in = 0;
    @(posedge clk); #1;
    check("rev.clear", 32'(b1.valid_out), 32'd0);

    // N=5 out-of-range handling
    @(negedge clk); b2.valid_in = 1; b2.index_in = 6; b2.last_in = 1; b2.ready_out = 0;
    @(posedge clk); #1;
    check("oor.valid_out", 32'(b2.valid_out), 32'd1);
    check("oor.mask_out",  32'(b2.mask_out),  32'd0);
    check("oor.count_out", 32'(b2.count_out), 32'd0);
    check("oor.err_out",   32'(b2.err_out),   32'(EXP_ERR));
    @(negedge clk); b2.index_in = 4; b2.ready_out = 1;
    @(posedge clk); #1;
    check("n5_4.mask_out", 32'(b2.mask_out),  32'h10);
    check("n5_4.count",    32'(b2.count_out), 32'd1);
    check("n5_4.err_out",  32'(b2.err_out),   32'd0);
    @(negedge clk); b2.index_in = 2; b2.last_in = 0;
    @(posedge clk); #1;
    @(negedge clk); b2.index_in = 6; b2.last_in = 1; b2.ready_out = 0;
    @(posedge clk); #1;
    check("oor2.mask_out", 32'(b2.mask_out),  32'h04);
    check("oor2.count",    32'(b2.count_out), 32'd1);
    check("oor2.dup_out",  32'(b2.dup_out),   32'd0);
    check("oor2.err_out",  32'(b2.err_out),   32'(EXP_ERR));
    @(negedge clk); b2.valid_in = 0; b2.ready_out = 1;
    @(posedge clk); #1;
    check("n5.clear_err", 32'(b2.err_out), 32'd0);

    // N=1
    @(negedge clk); b3.valid_in = 1; b3.index_in = 0; b3.last_in = 1; b3.ready_out = 0;
    @(posedge clk); #1;
    check("n1.mask_out",  32'(b3.mask_out),  32'd1);
    check("n1.count_out", 32'(b3.count_out), 32'd1);
    @(negedge clk); b3.index_in = 1; b3.ready_out = 1;
    @(posedge clk); #1;
    check("n1_oor.mask_out",  32'(b3.mask_out),  32'd0);
    check("n1_oor.count_out", 32'(b3.count_out), 32'd0);
    check("n1_oor.err_out",   32'(b3.err_out),   32'(EXP_ERR));
    @(negedge clk); b3.valid_in = 0;

    // Report
    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vx_onehot_collector.md
VX_ONEHOT_COLLECTOR -- requirements
Module: VX_onehot_collector

Interface
REQ-001 SHALL have parameter N, default 1: width of the output mask (N >= 1).
REQ-002 SHALL have parameter REVERSE, default 0: when 1, index i maps to mask bit N-1-i.
REQ-003 SHALL have parameter LN, default `LOG2UP(N): index width.
REQ-004 SHALL have parameter CW, default `CLOG2(N+1): width of the distinct-bit count.
REQ-005 SHALL have port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-007 SHALL have port valid_in, input, 1: an input beat is present.
REQ-008 SHALL have port index_in, input, LN: index to decode into the mask.
REQ-009 SHALL have port last_in, input, 1: the beat closes the current group.
REQ-010 SHALL have port ready_in, output, 1: the block accepts a beat this cycle.
REQ-011 SHALL have port valid_out, output, 1: a completed group is presented.
REQ-012 SHALL have port mask_out, output, N: OR of the decoded one-hot beats of the group.
REQ-013 SHALL have port count_out, output, CW: number of distinct bits set in mask_out.
REQ-014 SHALL have port dup_out, output, 1: at least one beat of the group hit an already-set bit.
REQ-015 SHALL have port err_out, output, 1: the group contained an out-of-range index (see Configuration).
REQ-016 SHALL have port ready_out, input, 1: the consumer accepts the presented group.

Function
REQ-017 SHALL implement states IDLE (empty accumulator), ACCUM (at least one beat and no last seen) and HOLD (group complete, valid_out=1).
REQ-018 SHALL accept a beat when valid_in && ready_in; ready_in = (state != HOLD) || ready_out.
REQ-019 An accepted beat SHALL OR decode(index_in) into the accumulator and apply to outputs from the next cycle: latency 1 cycle from the last beat to valid_out.
REQ-020 Transitions: an accepted beat with last_in=0 goes IDLE/ACCUM->ACCUM; an accepted beat with last_in=1 goes IDLE/ACCUM->HOLD.
REQ-021 In HOLD with ready_out=1 and no beat accepted, the block SHALL go to IDLE and clear the accumulator, count, dup and err.
REQ-022 In HOLD with ready_out=1 and a simultaneous accepted beat, the block SHALL start a fresh group from that beat only (state ACCUM, or HOLD if last_in=1), with no cycle bubble.
REQ-023 valid_out, mask_out, count_out, dup_out and err_out SHALL be registered and stable while valid_out=1 && ready_out=0.
REQ-024 count_out SHALL increment only when a beat sets a previously-clear bit; it SHALL never exceed N.
REQ-025 dup_out SHALL be sticky within a group; a repeated index leaves mask_out and count_out unchanged.
REQ-026 For N==1, in-range index 0 SHALL set mask bit 0.
REQ-027 A single-beat group (IDLE plus a beat with last_in=1) SHALL produce a one-hot mask_out with count_out=1.
REQ-028 Outputs SHALL NOT depend combinationally on valid_in or index_in; ready_in MAY depend combinationally on ready_out.

Reset
REQ-029 While reset=1, the block SHALL enter state IDLE and drive valid_out=0, mask_out=0, count_out=0, dup_out=0, err_out=0.
REQ-030 ready_in SHALL be 1 in the cycle after reset deasserts.
REQ-031 Reset asserted mid-group or in HOLD SHALL discard the partial or held group, and no output handshake SHALL occur for it.

Configuration
REQ-032 Macro VX_ONEHOT_COLLECTOR_RANGE_CHECK_EN SHALL control out-of-range checking.
REQ-033 When the macro is defined, an accepted beat with index_in >= N SHALL set no mask bit and SHALL set err_out sticky for the group.
REQ-034 When the macro is undefined, an accepted beat with index_in >= N SHALL set no mask bit and err_out SHALL be tied to 0.

Verification
REQ-035 With N=8 and REVERSE=0, beats 3, 5, 0 (last on the third beat) SHALL produce mask_out=8'b00101001, count_out=3, dup_out=0 one cycle after the last beat.
REQ-036 With N=8 and REVERSE=1, a single beat index=0 with last_in=1 SHALL produce mask_out=8'b10000000, count_out=1.
REQ-037 With N=8, beats 2, 2 (last) SHALL produce mask_out=8'b00000100, count_out=1, dup_out=1.
REQ-038 With ready_out=0 for 4 cycles in HOLD, ready_in SHALL be 0 and the outputs stable; on the cycle ready_out=1 and a beat index=7 with last_in=1 arrive, the next output SHALL be mask_out=8'h80 with no bubble.
REQ-039 With N=5, a beat index=6 with last_in=1 SHALL produce mask_out=0, count_out=0 and err_out=1 with the macro defined, or err_out=0 without it.
REQ-040 Reset pulsed after beats 1 and 4 (no last), followed by a beat 0 with last_in=1, SHALL produce mask_out=8'b00000001 and count_out=1.
